// File: rtl/bin_search_pkg.sv
// Shared definitions for the binary-search controller: FSM state encoding,
// one-hot comparator flag codes and the default operand width.
package bin_search_pkg;

    // Default operand / probe width
    localparam int DEFAULT_WIDTH = 8;

    // Controller states: one probe runs SET -> WAIT -> EVAL
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SET  = 3'd1,
        ST_WAIT = 3'd2,
        ST_EVAL = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Comparator flags packed as {equal, larger, smaller}; exactly one is legal
    localparam logic [2:0] FLAG_EQ = 3'b100;
    localparam logic [2:0] FLAG_GT = 3'b010;
    localparam logic [2:0] FLAG_LT = 3'b001;

endpackage

// File: rtl/bin_search_ctrl_dp.sv
// Search-range datapath: holds the lo/hi bounds and the registered probe
// (midpoint), and reports when the probe sits on either end of the range.
module bin_search_dp
    import bin_search_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             load_mid,
    input  logic             step_up,
    input  logic             step_down,
    output logic [WIDTH-1:0] probe,
    output logic             at_lo,
    output logic             at_hi
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] mid;

    // Midpoint uses one extra bit so lo+hi can never overflow
    assign sum = {1'b0, lo} + {1'b0, hi};
    assign mid = sum[WIDTH:1];

    // Range bounds and probe register; probe keeps its value between searches
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lo    <= '0;
            hi    <= MAX_VAL;
            probe <= '0;
        end else begin
            if (init) begin
                lo <= '0;
                hi <= MAX_VAL;
            end else begin
                if (step_up) begin
                    lo <= probe + ONE;
                end
                if (step_down) begin
                    hi <= probe - ONE;
                end
            end
            if (load_mid) begin
                probe <= mid;
            end
        end
    end

    // A probe on a range end cannot move further that way without wrapping
    assign at_lo = (probe == lo);
    assign at_hi = (probe == hi);

endmodule

// File: rtl/bin_search_ctrl.sv
// Binary-search controller: drives the comparator B operand, waits out the
// comparator latency, then narrows the range from the equal/larger/smaller
// flags until a match, an exhausted range, bad flags or the probe budget.
module bin_search_ctrl
    import bin_search_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int CMP_LAT   = 1,
    parameter int MAX_STEPS = WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             equal,
    input  logic             larger,
    input  logic             smaller,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       steps
);

    localparam int             CW         = $clog2(CMP_LAT + 1);
    localparam logic [CW-1:0]  LAT_LOAD   = CW'(CMP_LAT);
    localparam logic [CW-1:0]  CNT_ONE    = CW'(1);
    localparam logic [3:0]     STEP_LIMIT = 4'(MAX_STEPS);

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   wait_cnt;
    logic [2:0]      flags;
    logic [3:0]      steps_inc;
    logic            dp_init;
    logic            dp_load;
    logic            dp_up;
    logic            dp_down;
    logic            hit;
    logic            miss;
    logic            at_lo;
    logic            at_hi;

    assign flags = {equal, larger, smaller};

    bin_search_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk       (clk),
        .rst       (rst),
        .init      (dp_init),
        .load_mid  (dp_load),
        .step_up   (dp_up),
        .step_down (dp_down),
        .probe     (probe),
        .at_lo     (at_lo),
        .at_hi     (at_hi)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus datapath strobes and the hit/miss verdict of each probe
    always_comb begin
        state_next = state;
        dp_init    = 1'b0;
        dp_load    = 1'b0;
        dp_up      = 1'b0;
        dp_down    = 1'b0;
        hit        = 1'b0;
        miss       = 1'b0;
        steps_inc  = steps + 4'd1;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    dp_init    = 1'b1;
                    state_next = ST_SET;
                end
            end
            ST_SET: begin
                dp_load    = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt == CNT_ONE) begin
                    state_next = ST_EVAL;
                end
            end
            ST_EVAL: begin
                state_next = ST_DONE;
                case (flags)
                    FLAG_EQ: begin
                        hit = 1'b1;
                    end
                    FLAG_GT: begin
                        if (at_hi || (steps_inc == STEP_LIMIT)) begin
                            miss = 1'b1;
                        end else begin
                            dp_up      = 1'b1;
                            state_next = ST_SET;
                        end
                    end
                    FLAG_LT: begin
                        if (at_lo || (steps_inc == STEP_LIMIT)) begin
                            miss = 1'b1;
                        end else begin
                            dp_down    = 1'b1;
                            state_next = ST_SET;
                        end
                    end
                    default: begin
                        miss = 1'b1;
                    end
                endcase
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Wait counter, step counter and the user-visible status registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
            steps    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            found    <= 1'b0;
            result   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        steps  <= '0;
                        found  <= 1'b0;
                        result <= '0;
                        busy   <= 1'b1;
                    end
                end
                ST_SET: begin
                    wait_cnt <= LAT_LOAD;
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - CNT_ONE;
                end
                ST_EVAL: begin
                    steps <= steps_inc;
                    if (hit) begin
                        found  <= 1'b1;
                        result <= probe;
                    end
                    if (miss) begin
                        found  <= 1'b0;
                        result <= '0;
                    end
                    if (hit || miss) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
